nrzi_bit_decoder: RTL

Bit-level receive stage that sits directly after the two-flop line synchronizer, whose output idles high. It detects the start of a packet on the synchronized serial line, recovers bit timing with a resynchronizing bit-period counter, and samples each bit at mid-period. It NRZI-decodes the samples, strips stuffed bits, and emits decoded bits as single-cycle strobes to the downstream shift/packet logic. It also flags end-of-packet (line returns to idle) and bit-stuffing violations (line stuck low).

---
 rtl/nrzi_bit_decoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/nrzi_bit_decoder.sv
// NRZI bit-level receive stage: packet-start detect, bit-timing recovery with a
// resynchronising phase counter, mid-bit sampling, NRZI decode and destuffing.
module nrzi_bit_decoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_in,
  input  logic rx_enable,
  output logic bit_out,
  output logic bit_valid,
  output logic eop,
  output logic stuff_err,
  output logic rx_idle
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic {
    IDLE,
    RX
  } state_e;

  state_e          state_q, state_d;
  logic            prev_q, prev_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_lvl_q, last_lvl_d;
  logic [2:0]      ones_cnt_q, ones_cnt_d;
  logic            bit_out_q, bit_out_d;
  logic            bit_valid_q, bit_valid_d;
  logic            eop_q, eop_d;
  logic            stuff_err_q, stuff_err_d;

  logic            transition;
  logic            sample_pt;
  logic            dec;

  assign transition = d_in ^ prev_q;
  assign sample_pt  = (cnt_q == CW'(HALF));
  assign dec        = ~(d_in ^ last_lvl_q);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      last_lvl_q  <= 1'b1;
      ones_cnt_q  <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      eop_q       <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      last_lvl_q  <= last_lvl_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      eop_q       <= eop_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = d_in;
    cnt_d       = cnt_q;
    last_lvl_d  = last_lvl_q;
    ones_cnt_d  = ones_cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    eop_d       = 1'b0;
    stuff_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_enable && prev_q && !d_in) begin
          state_d    = RX;
          last_lvl_d = 1'b1;
          ones_cnt_d = '0;
        end
      end

      RX: begin
        if (!rx_enable) begin
          state_d = IDLE;
        end else begin
          // Any edge re-aligns the phase counter, even on the sample cycle itself.
          if (transition || (cnt_q == CW'(CLKS_PER_BIT - 1))) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end

          if (sample_pt) begin
            last_lvl_d = d_in;
            if (ones_cnt_q < 3'd6) begin
              bit_valid_d = 1'b1;
              bit_out_d   = dec;
              ones_cnt_d  = dec ? (ones_cnt_q + 3'd1) : 3'd0;
            end else if (!dec) begin
              ones_cnt_d = '0;
            end else begin
              eop_d       = d_in;
              stuff_err_d = ~d_in;
              state_d     = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign eop       = eop_q;
  assign stuff_err = stuff_err_q;
  assign rx_idle   = (state_q == IDLE);

endmodule
